// File: rtl/acc_drain_seq.sv
// acc_drain_seq: drains four 4-entry accumulator banks to a ready/valid stream
// Ports:
//    clk, rst        clock and synchronous active-high reset
//    start           one-cycle drain request, honoured only when idle
//    buff_full[3:0]  bank b holds four valid entries
//    acc_in          16 flattened DATA_W entries, slice 4*bank+entry, LSB-first
//    out_ready       downstream accepts out_data this cycle
//    out_valid       out_data holds a valid entry
//    out_data        registered entry on offer
//    custom_mux_sel  {bank, entry} of the entry on offer
//    buff_clear      one-cycle pulse per bank once its last entry is accepted
//    busy            high outside IDLE
//    done            one-cycle pulse once all 16 entries are accepted
module acc_drain_seq #(
   parameter int DATA_W = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [3:0]           buff_full,
   input  logic [16*DATA_W-1:0] acc_in,
   input  logic                 out_ready,
   output logic                 out_valid,
   output logic [DATA_W-1:0]    out_data,
   output logic [3:0]           custom_mux_sel,
   output logic [3:0]           buff_clear,
   output logic                 busy,
   output logic                 done
);
   typedef enum logic [1:0] {IDLE, WAIT, SEND, DONE} state_t;
   state_t state;
   logic [1:0] bank, entry;
   logic [DATA_W-1:0] ent [16];
   for (genvar i = 0; i < 16; i++) begin : g_ent
      assign ent[i] = acc_in[i*DATA_W +: DATA_W];
   end
   assign custom_mux_sel = {bank, entry};
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         bank       <= '0;
         entry      <= '0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         buff_clear <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         buff_clear <= '0;
         done       <= 1'b0;
         case (state)
            IDLE: if (start) begin
               state <= WAIT;
               busy  <= 1'b1;
               bank  <= '0;
               entry <= '0;
            end
            WAIT: if (buff_full[bank]) begin
               state     <= SEND;
               out_valid <= 1'b1;
               out_data  <= ent[{bank, 2'd0}];
            end
            SEND: if (out_ready) begin
               if (entry != 2'd3) begin
                  // next entry is captured on the accepting edge for full throughput
                  entry    <= entry + 2'd1;
                  out_data <= ent[{bank, entry + 2'd1}];
               end else begin
                  out_valid  <= 1'b0;
                  entry      <= '0;
                  buff_clear <= 4'b0001 << bank;
                  if (bank == 2'd3) begin
                     state <= DONE;
                     done  <= 1'b1;
                     bank  <= '0;
                  end else begin
                     state <= WAIT;
                     bank  <= bank + 2'd1;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_acc_drain_seq.sv
// tb_acc_drain_seq: directed self-checking bench for acc_drain_seq
module tb_acc_drain_seq;
   logic clk = 0, rst = 1, start = 0, out_ready = 0;
   logic [3:0] buff_full = 0;
   logic [255:0] acc_in;
   logic out_valid, busy, done;
   logic [15:0] out_data;
   logic [3:0] custom_mux_sel, buff_clear;
   int checks = 0, failures = 0, dones = 0, onehot_bad = 0;
   logic [15:0] dq[$];
   logic [3:0] mq[$], cq[$];
   acc_drain_seq #(.DATA_W(16)) dut (
      .clk(clk), .rst(rst), .start(start), .buff_full(buff_full), .acc_in(acc_in),
      .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
      .custom_mux_sel(custom_mux_sel), .buff_clear(buff_clear), .busy(busy), .done(done)
   );
   always #5 clk = ~clk;
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         dq.push_back(out_data);
         mq.push_back(custom_mux_sel);
      end
      if (buff_clear != 0) cq.push_back(buff_clear);
      if ($countones(buff_clear) > 1) onehot_bad++;
      if (done) dones++;
   end
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic go;
      start = 1;
      tick;
      start = 0;
   endtask
   task automatic clr_logs;
      dq.delete();
      mq.delete();
      cq.delete();
      dones = 0;
   endtask
   task automatic set_acc;
      for (int i = 0; i < 16; i++) acc_in[i*16 +: 16] = 16'(i + 1);
   endtask
   task automatic wait_done(input string tag);
      int n = 0;
      while (dones == 0 && n < 300) begin
         tick;
         n++;
      end
      chk(tag, dones, 1);
      tick;
      tick;
   endtask
   task automatic wait_sel(input string tag, input logic [3:0] sel);
      int n = 0;
      while (!(out_valid && custom_mux_sel == sel) && n < 200) begin
         tick;
         n++;
      end
      chk(tag, custom_mux_sel, sel);
   endtask
   task automatic check_full(input string tag);
      chk({tag, "_cnt"}, dq.size(), 16);
      for (int i = 0; i < 16 && i < dq.size(); i++) begin
         chk({tag, "_data"}, dq[i], i + 1);
         chk({tag, "_sel"}, mq[i], i);
      end
      chk({tag, "_clr_cnt"}, cq.size(), 4);
      for (int i = 0; i < 4 && i < cq.size(); i++) chk({tag, "_clr"}, cq[i], 4'b0001 << i);
      chk({tag, "_dones"}, dones, 1);
   endtask
   initial begin
      bit pat [4] = '{1, 0, 0, 1};
      logic pv, pr;
      logic [15:0] pd;
      logic [3:0] pm;
      set_acc;
      tick;
      tick;
      chk("rst_valid", out_valid, 0);
      chk("rst_data", out_data, 0);
      chk("rst_sel", custom_mux_sel, 0);
      chk("rst_clr", buff_clear, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      rst = 0;
      tick;
      // full drain, cycle exact
      buff_full = 4'hF;
      out_ready = 1;
      clr_logs;
      go;
      chk("lat_busy", busy, 1);
      for (int b = 0; b < 4; b++) begin
         chk("wait_valid", out_valid, 0);
         chk("wait_clr", buff_clear, b == 0 ? 4'h0 : 4'(4'b0001 << (b - 1)));
         for (int e = 0; e < 4; e++) begin
            tick;
            chk("send_valid", out_valid, 1);
            chk("send_data", out_data, 4 * b + e + 1);
            chk("send_sel", custom_mux_sel, 4 * b + e);
         end
         tick;
      end
      chk("done_pulse", done, 1);
      chk("done_clr", buff_clear, 4'b1000);
      chk("done_busy", busy, 1);
      tick;
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
      check_full("full");
      tick;
      // backpressure 1,0,0,1
      clr_logs;
      go;
      for (int k = 0; k < 300 && dones == 0; k++) begin
         pv = out_valid;
         pd = out_data;
         pm = custom_mux_sel;
         out_ready = pat[k % 4];
         pr = out_ready;
         tick;
         if (pv && !pr) begin
            chk("hold_data", out_data, pd);
            chk("hold_sel", custom_mux_sel, pm);
         end
      end
      out_ready = 1;
      tick;
      tick;
      check_full("bp");
      // bank stall
      clr_logs;
      buff_full = 4'b0011;
      go;
      repeat (30) tick;
      chk("stall_cnt", dq.size(), 8);
      chk("stall_busy", busy, 1);
      chk("stall_valid", out_valid, 0);
      chk("stall_sel", custom_mux_sel, 4'b1000);
      buff_full = 4'b0111;
      tick;
      chk("resume_valid", out_valid, 1);
      chk("resume_sel", custom_mux_sel, 4'b1000);
      chk("resume_data", out_data, 9);
      buff_full = 4'hF;
      wait_done("stall_to");
      check_full("stall");
      // start while busy
      clr_logs;
      go;
      wait_sel("sb_sel", 4'b0101);
      go;
      wait_done("sb_to");
      check_full("sb");
      repeat (5) tick;
      chk("sb_idle", busy, 0);
      // reset mid-drain
      clr_logs;
      go;
      wait_sel("rm_sel", 4'b0110);
      rst = 1;
      tick;
      rst = 0;
      chk("rm_valid", out_valid, 0);
      chk("rm_data", out_data, 0);
      chk("rm_sel0", custom_mux_sel, 0);
      chk("rm_clr", buff_clear, 0);
      chk("rm_busy", busy, 0);
      chk("rm_done", done, 0);
      repeat (5) tick;
      chk("rm_clr_cnt", cq.size(), 1);
      chk("rm_dones", dones, 0);
      chk("rm_xfers", dq.size(), 6);
      clr_logs;
      go;
      tick;
      chk("rs_valid", out_valid, 1);
      chk("rs_data", out_data, 1);
      chk("rs_sel", custom_mux_sel, 0);
      wait_done("rs_to");
      check_full("rs");
      // acc_in change while offered
      clr_logs;
      go;
      wait_sel("ac_sel", 4'b0101);
      out_ready = 0;
      acc_in[5*16 +: 16] = 16'hBEEF;
      repeat (3) tick;
      chk("ac_valid", out_valid, 1);
      chk("ac_data", out_data, 6);
      chk("ac_sel2", custom_mux_sel, 4'b0101);
      out_ready = 1;
      tick;
      chk("ac_next", out_data, 7);
      wait_done("ac_to");
      chk("ac_cnt", dq.size(), 16);
      if (dq.size() > 5) chk("ac_xfer5", dq[5], 6);
      set_acc;
      chk("onehot", onehot_bad, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
